// File: rtl/janus_pkg.sv
// Shared encodings for the data-in-bus read path.
// Holds the access-size codes, the read FSM states and the alignment check.
package janus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_e;

  // An access is unusable if it has the reserved size code, or if it does not
  // start on a boundary of its own size. A byte is always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dib_align.sv
// Lane select plus sign/zero extension of a little-endian memory word.
// Purely combinational so that the load path can reuse it as-is.
module dib_align
  import janus_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, then fill the upper bits with its MSB or zero.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_byte = i_rdata[7:0];
    w_half = i_rdata[15:0];
    o_data = i_rdata;

    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase

    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dib_rd_if.sv
// Memory read interface that produces the 32-bit data-in bus (dib).
// One read per rd_start: word-aligned req/ack handshake, lane extraction,
// extension, a registered result and a one-cycle dib_valid strobe. Illegal
// accesses and memory timeouts raise a sticky rd_err instead.
module dib_rd_if
  import janus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] RST_DIB = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_start,
  input  logic [31:0] rd_addr,
  input  logic [1:0]  rd_size,
  input  logic        rd_signed,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] dib,
  output logic        dib_valid,
  output logic        rd_err
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        r_state;
  state_e        w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_addr_lo;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_dib;
  logic          r_rd_err;

  logic          w_accept;
  logic          w_misal;
  logic          w_ack;
  logic          w_timeout;
  logic [31:0]   w_aligned;

  // rd_start only counts in IDLE; the ack is only meaningful while waiting.
  // An ack in the last waiting cycle wins over the timeout.
  assign w_accept  = (r_state == S_IDLE) && rd_start;
  assign w_misal   = is_misaligned(rd_size, rd_addr[1:0]);
  assign w_ack     = (r_state == S_WAIT) && mem_ack;
  assign w_timeout = (r_state == S_WAIT) && !mem_ack && (r_cnt == CNT_LAST);

  dib_align u_align (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .o_data    (w_aligned)
  );

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode: illegal accesses skip the memory and go straight to ERR.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_misal ? S_ERR : S_WAIT;
      S_WAIT: begin
        if (w_ack)          w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the request attributes on accept; they steer lane extraction later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_lo  <= 2'b00;
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_mem_addr <= 32'h0000_0000;
    end else if (w_accept) begin
      r_addr_lo <= rd_addr[1:0];
      r_size    <= rd_size;
      r_signed  <= rd_signed;
      if (!w_misal) r_mem_addr <= {rd_addr[31:2], 2'b00};
    end
  end

  // Wait-cycle counter: zeroed on accept, counts every cycle spent in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (w_accept)           r_cnt <= '0;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt + CNT_ONE;
  end

  // Result register: loaded only on a real ack, otherwise holds the last read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_dib <= RST_DIB;
    else if (w_ack) r_dib <= w_aligned;
  end

  // Sticky error: re-evaluated on each accept, set again by a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rd_err <= 1'b0;
    else if (w_accept)  r_rd_err <= w_misal;
    else if (w_timeout) r_rd_err <= 1'b1;
  end

  assign busy      = (r_state != S_IDLE);
  assign mem_req   = (r_state == S_WAIT);
  assign dib_valid = (r_state == S_DONE);
  assign mem_addr  = r_mem_addr;
  assign dib       = r_dib;
  assign rd_err    = r_rd_err;

endmodule

// File: tb/tb_dib_rd_if.sv
// Self-checking bench for dib_rd_if: scoreboard of expected dib values,
// pushed when a read is issued and popped on each dib_valid strobe.
`timescale 1ns/1ps
module tb_dib_rd_if;

  logic        clk;
  logic        rst_n;
  logic        rd_start;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic        rd_signed;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] dib;
  logic        dib_valid;
  logic        rd_err;

  int          n_checks;
  int          n_errors;
  int          n_valid;
  logic [31:0] exp_q[$];
  logic [31:0] last_dib;

  dib_rd_if #(.TIMEOUT(16), .RST_DIB(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_start  (rd_start),
    .rd_addr   (rd_addr),
    .rd_size   (rd_size),
    .rd_signed (rd_signed),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dib       (dib),
    .dib_valid (dib_valid),
    .rd_err    (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference lane/extension model, written as shift-and-mask.
  function automatic logic [31:0] ref_dib(input logic [31:0] rdata, input logic [1:0] lo,
                                          input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (rdata >> (8 * lo)) & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (rdata >> (lo[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Scoreboard: each dib_valid strobe must match the oldest outstanding read.
  initial begin
    forever begin
      @(negedge clk);
      if (dib_valid) begin
        n_valid++;
        if (exp_q.size() == 0) check("sb_unexpected_valid", 32'd1, 32'd0);
        else                   check("sb_dib", dib, exp_q.pop_front());
      end
    end
  end

  // Legal read with the memory acking ack_dly cycles after mem_req first rises.
  // Called just after a rising edge with the DUT idle; returns likewise.
  task automatic do_read(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] rdata, input int ack_dly, input logic [31:0] exp);
    rd_start  = 1'b1;
    rd_addr   = addr;
    rd_size   = size;
    rd_signed = sgn;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    rd_start = 1'b0;
    check("mem_req_rise", {31'd0, mem_req}, 32'd1);
    check("mem_addr", mem_addr, {addr[31:2], 2'b00});
    check("rd_err_clear", {31'd0, rd_err}, 32'd0);
    repeat (ack_dly) begin
      @(posedge clk); #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    check("mem_req_drop", {31'd0, mem_req}, 32'd0);
    check("dib_valid_done", {31'd0, dib_valid}, 32'd1);
    check("dib_done", dib, exp);
    @(posedge clk); #1;
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("dib_valid_off", {31'd0, dib_valid}, 32'd0);
    last_dib = exp;
  endtask

  // Illegal access: no memory request, sticky error, dib untouched.
  task automatic bad_read(input logic [31:0] addr, input logic [1:0] size);
    rd_start  = 1'b1;
    rd_addr   = addr;
    rd_size   = size;
    rd_signed = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    check("bad_no_req", {31'd0, mem_req}, 32'd0);
    check("bad_rd_err", {31'd0, rd_err}, 32'd1);
    check("bad_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("bad_back_idle", {31'd0, busy}, 32'd0);
    check("bad_dib_hold", dib, last_dib);
    check("bad_no_valid", {31'd0, dib_valid}, 32'd0);
  endtask

  initial begin
    int          v0;
    int          cnt;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic        g;

    n_checks  = 0;
    n_errors  = 0;
    n_valid   = 0;
    last_dib  = 32'h0;
    rst_n     = 1'b0;
    rd_start  = 1'b0;
    rd_addr   = 32'h0;
    rd_size   = 2'b00;
    rd_signed = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // Reset values.
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_dib", dib, 32'h0);
    check("rst_dib_valid", {31'd0, dib_valid}, 32'd0);
    check("rst_rd_err", {31'd0, rd_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed byte in the top lane, ack two cycles late: exactly one strobe.
    v0 = n_valid;
    do_read(32'h0000_1003, 2'b00, 1'b1, 32'h80AA_BBCC, 2, 32'hFFFF_FF80);
    check("one_valid_pulse", n_valid - v0, 32'd1);

    // Upper half, unsigned then signed.
    do_read(32'h0000_2002, 2'b01, 1'b0, 32'hDDDD_1234, 1, 32'h0000_DDDD);
    do_read(32'h0000_2002, 2'b01, 1'b1, 32'hDDDD_1234, 1, 32'hFFFF_DDDD);

    // Word with the ack in the first mem_req cycle: strobe two edges after
    // rd_start is driven, busy low one cycle after that.
    do_read(32'h0000_3000, 2'b10, 1'b1, 32'h1357_9BDF, 0, 32'h1357_9BDF);

    // Misaligned half and reserved size, then a good read clears rd_err.
    bad_read(32'h0000_4001, 2'b01);
    bad_read(32'h0000_4000, 2'b11);
    do_read(32'h0000_4000, 2'b00, 1'b0, 32'h0000_00F0, 1, 32'h0000_00F0);

    // Timeout: mem_req high for exactly 16 cycles; a rd_start inside WAIT is ignored.
    rd_start  = 1'b1;
    rd_addr   = 32'h0000_6004;
    rd_size   = 2'b10;
    rd_signed = 1'b0;
    @(posedge clk); #1;
    rd_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      cnt++;
      rd_start = (i == 4);
      rd_addr  = (i == 4) ? 32'h0000_7000 : 32'h0000_6004;
      rd_size  = 2'b00;
      @(posedge clk); #1;
    end
    rd_start = 1'b0;
    check("timeout_req_cycles", cnt, 32'd16);
    check("timeout_rd_err", {31'd0, rd_err}, 32'd1);
    check("timeout_addr_held", mem_addr, 32'h0000_6004);
    check("timeout_no_valid", {31'd0, dib_valid}, 32'd0);
    @(posedge clk); #1;
    check("timeout_idle", {31'd0, busy}, 32'd0);
    // Late ack after returning to IDLE must be ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("late_ack_dib", dib, last_dib);
    check("late_ack_no_valid", {31'd0, dib_valid}, 32'd0);
    check("late_ack_rd_err", {31'd0, rd_err}, 32'd1);

    // Mixed legal reads against the reference model.
    for (int k = 0; k < 8; k++) begin
      s = 2'($urandom_range(0, 2));
      a = $urandom;
      if (s == 2'b01) a[0] = 1'b0;
      if (s == 2'b10) a[1:0] = 2'b00;
      d = $urandom;
      g = 1'($urandom_range(0, 1));
      do_read(a, s, g, d, int'($urandom_range(0, 3)), ref_dib(d, a[1:0], s, g));
    end

    // Reset in the middle of WAIT: immediate reset values, later ack ignored.
    rd_start  = 1'b1;
    rd_addr   = 32'h0000_8008;
    rd_size   = 2'b10;
    rd_signed = 1'b0;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    check("mid_rst_dib", dib, 32'h0);
    check("mid_rst_rd_err", {31'd0, rd_err}, 32'd0);
    #2 rst_n = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b0;
    @(posedge clk); #1;
    check("post_rst_dib", dib, 32'h0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_no_valid", {31'd0, dib_valid}, 32'd0);

    repeat (2) @(posedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
